// File: rtl/cpu_pkg.sv
// Shared types and constants for the five-stage 32-bit pipelined CPU.
package cpu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned CTRL_W = 10;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_NOR = 4'd5,
    ALU_SLT = 4'd6,
    ALU_SLL = 4'd7,
    ALU_SRL = 4'd8,
    ALU_SRA = 4'd9,
    ALU_LUI = 4'd10
  } alu_op_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    alu_src;
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    branch;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = ctrl_t'(10'd0);

  // Write-back forwarding hit; register 0 is hardwired and never forwarded.
  function automatic logic wb_hit(input logic             we,
                                  input logic [REG_W-1:0] waddr,
                                  input logic [REG_W-1:0] raddr);
    return we && (waddr != REG_ZERO) && (waddr == raddr);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the load in EX and the instruction in ID.
module hazard_detect
  import cpu_pkg::*;
(
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  output logic             hz_c
);

  logic rs_match;
  logic rt_match;

  always_comb begin
    rs_match = (ex_rt == id_rs);
    rt_match = id_uses_rt & (ex_rt == id_rt);
    hz_c     = ex_valid & ex_mem_read & (ex_rt != REG_ZERO) & id_valid
             & (rs_match | rt_match);
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: load-use stall, flush/stall bubbles, hold, and
// write-back bypass into the captured operands.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [PC_W-1:0]   id_pc,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              id_uses_rt,
  input  logic [XLEN-1:0]   id_rs_data,
  input  logic [XLEN-1:0]   id_rt_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              wb_we,
  input  logic [REG_W-1:0]  wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              flush,
  input  logic              hold,
  output logic              stall_o,
  output logic              ex_valid,
  output logic [PC_W-1:0]   ex_pc,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [REG_W-1:0]  ex_rd,
  output logic [XLEN-1:0]   ex_rs_data,
  output logic [XLEN-1:0]   ex_rt_data,
  output logic [XLEN-1:0]   ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CNT_W-1:0]  bubble_cnt
);

  ctrl_t id_ctrl_s;
  logic  hz_c;

  logic             ex_valid_q,   ex_valid_d;
  logic [PC_W-1:0]  ex_pc_q,      ex_pc_d;
  logic [REG_W-1:0] ex_rs_q,      ex_rs_d;
  logic [REG_W-1:0] ex_rt_q,      ex_rt_d;
  logic [REG_W-1:0] ex_rd_q,      ex_rd_d;
  logic [XLEN-1:0]  ex_rs_data_q, ex_rs_data_d;
  logic [XLEN-1:0]  ex_rt_data_q, ex_rt_data_d;
  logic [XLEN-1:0]  ex_imm_q,     ex_imm_d;
  ctrl_t            ex_ctrl_q,    ex_ctrl_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  assign id_ctrl_s = ctrl_t'(id_ctrl);

  hazard_detect u_hazard_detect (
    .ex_valid    (ex_valid_q),
    .ex_mem_read (ex_ctrl_q.mem_read),
    .ex_rt       (ex_rt_q),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .hz_c        (hz_c)
  );

  // A flush kills the wrong-path decode instruction upstream, so it never stalls.
  always_comb begin
    stall_o = hz_c & ~flush & ~hold;
  end

  // Next-state: flush > hold > load-use bubble > normal load.
  always_comb begin
    ex_valid_d   = ex_valid_q;
    ex_pc_d      = ex_pc_q;
    ex_rs_d      = ex_rs_q;
    ex_rt_d      = ex_rt_q;
    ex_rd_d      = ex_rd_q;
    ex_rs_data_d = ex_rs_data_q;
    ex_rt_data_d = ex_rt_data_q;
    ex_imm_d     = ex_imm_q;
    ex_ctrl_d    = ex_ctrl_q;
    bubble_cnt_d = bubble_cnt_q;

    if (flush || (!hold && hz_c)) begin
      ex_valid_d   = 1'b0;
      ex_pc_d      = '0;
      ex_rs_d      = REG_ZERO;
      ex_rt_d      = REG_ZERO;
      ex_rd_d      = REG_ZERO;
      ex_rs_data_d = '0;
      ex_rt_data_d = '0;
      ex_imm_d     = '0;
      ex_ctrl_d    = CTRL_NOP;
      if (!flush && (bubble_cnt_q != {CNT_W{1'b1}})) begin
        bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
      end
    end else if (!hold) begin
      ex_valid_d   = id_valid;
      ex_pc_d      = id_pc;
      ex_rs_d      = id_rs;
      ex_rt_d      = id_rt;
      ex_rd_d      = id_rd;
      ex_imm_d     = id_imm;
      ex_ctrl_d    = id_valid ? id_ctrl_s : CTRL_NOP;
      ex_rs_data_d = wb_hit(wb_we, wb_addr, id_rs) ? wb_data : id_rs_data;
      ex_rt_data_d = wb_hit(wb_we, wb_addr, id_rt) ? wb_data : id_rt_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q   <= 1'b0;
      ex_pc_q      <= '0;
      ex_rs_q      <= REG_ZERO;
      ex_rt_q      <= REG_ZERO;
      ex_rd_q      <= REG_ZERO;
      ex_rs_data_q <= '0;
      ex_rt_data_q <= '0;
      ex_imm_q     <= '0;
      ex_ctrl_q    <= CTRL_NOP;
      bubble_cnt_q <= '0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_pc_q      <= ex_pc_d;
      ex_rs_q      <= ex_rs_d;
      ex_rt_q      <= ex_rt_d;
      ex_rd_q      <= ex_rd_d;
      ex_rs_data_q <= ex_rs_data_d;
      ex_rt_data_q <= ex_rt_data_d;
      ex_imm_q     <= ex_imm_d;
      ex_ctrl_q    <= ex_ctrl_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_pc      = ex_pc_q;
  assign ex_rs      = ex_rs_q;
  assign ex_rt      = ex_rt_q;
  assign ex_rd      = ex_rd_q;
  assign ex_rs_data = ex_rs_data_q;
  assign ex_rt_data = ex_rt_data_q;
  assign ex_imm     = ex_imm_q;
  assign ex_ctrl    = ex_ctrl_q;
  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus randomized traffic against a
// behavioural model; a second instance with a 2-bit counter covers saturation.
module tb_id_ex_stage;

  localparam logic [9:0] CTRL_LW  = 10'h03A;
  localparam logic [9:0] CTRL_ADD = 10'h010;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_uses_rt;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [9:0]  id_ctrl;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        flush, hold;

  logic        stall_o, ex_valid;
  logic [31:0] ex_pc, ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [9:0]  ex_ctrl;
  logic [15:0] bubble_cnt;

  logic        s_stall_o, s_ex_valid;
  logic [31:0] s_ex_pc, s_ex_rs_data, s_ex_rt_data, s_ex_imm;
  logic [4:0]  s_ex_rs, s_ex_rt, s_ex_rd;
  logic [9:0]  s_ex_ctrl;
  logic [1:0]  s_bubble_cnt;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush), .hold(hold), .stall_o(stall_o), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_ctrl(ex_ctrl), .bubble_cnt(bubble_cnt)
  );

  id_ex_stage #(.PC_W(32), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush), .hold(hold), .stall_o(s_stall_o), .ex_valid(s_ex_valid),
    .ex_pc(s_ex_pc), .ex_rs(s_ex_rs), .ex_rt(s_ex_rt), .ex_rd(s_ex_rd),
    .ex_rs_data(s_ex_rs_data), .ex_rt_data(s_ex_rt_data), .ex_imm(s_ex_imm),
    .ex_ctrl(s_ex_ctrl), .bubble_cnt(s_bubble_cnt)
  );

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  // Behavioural model of what EX must hold; the bubble count is unbounded here.
  logic        m_valid;
  logic [31:0] m_pc, m_rsd, m_rtd, m_imm;
  logic [4:0]  m_rs, m_rt, m_rd;
  logic [9:0]  m_ctrl;
  int          m_bubbles;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic bit model_hz();
    return m_valid && m_ctrl[3] && (m_rt != 5'd0) && id_valid &&
           ((m_rt == id_rs) || (id_uses_rt && (m_rt == id_rt)));
  endfunction

  task automatic model_clear();
    m_valid = 1'b0; m_pc = '0; m_rs = '0; m_rt = '0; m_rd = '0;
    m_rsd = '0; m_rtd = '0; m_imm = '0; m_ctrl = '0;
  endtask

  task automatic model_step();
    bit hz;
    hz = model_hz();
    if (rst) begin
      model_clear();
      m_bubbles = 0;
    end else if (flush) begin
      model_clear();
    end else if (!hold) begin
      if (hz) begin
        model_clear();
        m_bubbles++;
      end else begin
        m_valid = id_valid;
        m_pc    = id_pc;
        m_rs    = id_rs;
        m_rt    = id_rt;
        m_rd    = id_rd;
        m_imm   = id_imm;
        m_ctrl  = id_valid ? id_ctrl : 10'd0;
        m_rsd   = (wb_we && wb_addr != 5'd0 && wb_addr == id_rs) ? wb_data : id_rs_data;
        m_rtd   = (wb_we && wb_addr != 5'd0 && wb_addr == id_rt) ? wb_data : id_rt_data;
      end
    end
  endtask

  task automatic compare_model();
    logic exp_stall;
    int   c16, c2;
    if (!chk_en) return;
    exp_stall = model_hz() && !flush && !hold;
    c16 = (m_bubbles > 65535) ? 65535 : m_bubbles;
    c2  = (m_bubbles > 3) ? 3 : m_bubbles;
    chk("stall_o",      32'(stall_o),    32'(exp_stall));
    chk("ex_valid",     32'(ex_valid),   32'(m_valid));
    chk("ex_pc",        ex_pc,           m_pc);
    chk("ex_rs",        32'(ex_rs),      32'(m_rs));
    chk("ex_rt",        32'(ex_rt),      32'(m_rt));
    chk("ex_rd",        32'(ex_rd),      32'(m_rd));
    chk("ex_rs_data",   ex_rs_data,      m_rsd);
    chk("ex_rt_data",   ex_rt_data,      m_rtd);
    chk("ex_imm",       ex_imm,          m_imm);
    chk("ex_ctrl",      32'(ex_ctrl),    32'(m_ctrl));
    chk("bubble_cnt",   32'(bubble_cnt), 32'(c16));
    chk("sat_stall_o",  32'(s_stall_o),  32'(exp_stall));
    chk("sat_ex_valid", 32'(s_ex_valid), 32'(m_valid));
    chk("sat_ex_rs",    32'(s_ex_rs),    32'(m_rs));
    chk("sat_bubble",   32'(s_bubble_cnt), 32'(c2));
  endtask

  task automatic half();
    @(negedge clk);
    compare_model();
  endtask

  task automatic edge_();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic cyc();
    half();
    edge_();
  endtask

  task automatic idle();
    id_valid = 0; id_pc = '0; id_rs = '0; id_rt = '0; id_rd = '0; id_uses_rt = 0;
    id_rs_data = '0; id_rt_data = '0; id_imm = '0; id_ctrl = '0;
    wb_we = 0; wb_addr = '0; wb_data = '0; flush = 0; hold = 0;
  endtask

  task automatic set_id(input logic [31:0] pc, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic urt, input logic [9:0] ctrl);
    id_valid = 1; id_pc = pc; id_rs = rs; id_rt = rt; id_rd = rd;
    id_uses_rt = urt; id_ctrl = ctrl;
    id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
  endtask

  task automatic rand_inputs();
    id_valid   = ($urandom % 8) != 0;
    id_pc      = $urandom;
    id_rs      = 5'($urandom % 4);
    id_rt      = 5'($urandom % 4);
    id_rd      = 5'($urandom);
    id_uses_rt = 1'($urandom);
    id_rs_data = $urandom;
    id_rt_data = $urandom;
    id_imm     = $urandom;
    id_ctrl    = 10'($urandom);
    id_ctrl[3] = 1'($urandom);
    wb_we      = 1'($urandom);
    wb_addr    = 5'($urandom % 4);
    wb_data    = $urandom;
    flush      = ($urandom % 10) == 0;
    hold       = ($urandom % 7) == 0;
  endtask

  initial begin
    m_bubbles = 0;
    model_clear();

    // Reset with random inputs for two cycles.
    rst = 1;
    rand_inputs();
    edge_();
    chk_en = 1'b1;
    rand_inputs();
    cyc();
    rst = 0;
    idle();
    half();
    chk("rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_ex_pc", ex_pc, 32'd0);
    chk("rst_ex_ctrl", 32'(ex_ctrl), 32'd0);
    chk("rst_bubble_cnt", 32'(bubble_cnt), 32'd0);
    chk("rst_stall_o", 32'(stall_o), 32'd0);
    edge_();

    // Load-use: lw $5 then add $3,$5,$2.
    set_id(32'h40, 5'd1, 5'd5, 5'd0, 1'b0, CTRL_LW);
    cyc();
    set_id(32'h44, 5'd5, 5'd2, 5'd3, 1'b1, CTRL_ADD);
    half();
    chk("lu_stall", 32'(stall_o), 32'd1);
    edge_();
    half();
    chk("lu_bubble_valid", 32'(ex_valid), 32'd0);
    chk("lu_bubble_cnt", 32'(bubble_cnt), 32'd1);
    chk("lu_stall_drop", 32'(stall_o), 32'd0);
    edge_();
    idle();
    half();
    chk("lu_add_valid", 32'(ex_valid), 32'd1);
    chk("lu_add_rs", 32'(ex_rs), 32'd5);
    chk("lu_add_pc", ex_pc, 32'h44);
    edge_();

    // Write-back bypass, then the same with wb_addr = 0.
    set_id(32'h80, 5'd7, 5'd7, 5'd1, 1'b1, CTRL_ADD);
    id_rs_data = 32'h0; id_rt_data = 32'h11;
    wb_we = 1; wb_addr = 5'd7; wb_data = 32'hDEADBEEF;
    cyc();
    wb_addr = 5'd0;
    half();
    chk("byp_rs_data", ex_rs_data, 32'hDEADBEEF);
    chk("byp_rt_data", ex_rt_data, 32'hDEADBEEF);
    edge_();
    idle();
    half();
    chk("nobyp_rs_data", ex_rs_data, 32'h0);
    chk("nobyp_rt_data", ex_rt_data, 32'h11);
    edge_();

    // Flush while the load-use condition holds.
    set_id(32'h90, 5'd1, 5'd5, 5'd0, 1'b0, CTRL_LW);
    cyc();
    set_id(32'h94, 5'd5, 5'd2, 5'd3, 1'b1, CTRL_ADD);
    flush = 1;
    half();
    chk("fl_stall", 32'(stall_o), 32'd0);
    edge_();
    idle();
    half();
    chk("fl_valid", 32'(ex_valid), 32'd0);
    chk("fl_bubble_cnt", 32'(bubble_cnt), 32'd1);
    edge_();

    // Hold for three cycles with changing decode inputs.
    set_id(32'h100, 5'd1, 5'd2, 5'd3, 1'b1, CTRL_ADD);
    cyc();
    for (int i = 0; i < 3; i++) begin
      set_id($urandom, 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), CTRL_ADD);
      hold = 1;
      half();
      chk("hold_pc", ex_pc, 32'h100);
      chk("hold_stall", 32'(stall_o), 32'd0);
      edge_();
    end
    hold = 0;
    set_id(32'h200, 5'd4, 5'd6, 5'd8, 1'b0, CTRL_ADD);
    half();
    chk("hold_last_pc", ex_pc, 32'h100);
    edge_();
    idle();
    half();
    chk("release_pc", ex_pc, 32'h200);
    edge_();

    // Five back-to-back load-use bubbles after a reset.
    rst = 1;
    cyc();
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      set_id(32'h300, 5'd1, 5'd5, 5'd0, 1'b0, CTRL_LW);
      cyc();
      set_id(32'h304, 5'd5, 5'd2, 5'd3, 1'b1, CTRL_ADD);
      cyc();
      cyc();
    end
    idle();
    half();
    chk("sat_cnt16", 32'(bubble_cnt), 32'd5);
    chk("sat_cnt2", 32'(s_bubble_cnt), 32'd3);
    edge_();

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      rand_inputs();
      rst = ($urandom % 64) == 0;
      cyc();
    end
    rst = 0;
    idle();
    half();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
